// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   tx_state_e        : transmitter FSM state encoding (3 bits)
//   DefaultClksPerBit : default clocks per serial bit
//   FrameBits         : bits per 8N1 frame (start + 8 data + stop)
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StStart = 3'd3,
    StData  = 3'd4,
    StStop  = 3'd5
  } tx_state_e;

  localparam int unsigned DefaultClksPerBit = 16;
  localparam int unsigned FrameBits         = 10;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter for the UART transmitter.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset (count cleared to 0)
//   load   : reload CLKS_PER_BIT-1 (start of a new bit period)
//   enable : count down towards 0; holds at 0, never wraps
//   tick   : high while the count is 0 (last cycle of the bit period)
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] Reload = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = Reload;
    end else if (enable && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == 16'd0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO and sends them 8N1, LSB first.
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   empty        : upstream FIFO empty flag
//   full         : upstream FIFO full flag (read-acceptance detection only)
//   write_enable : upstream FIFO write strobe (monitored only)
//   dout         : upstream FIFO registered read data
//   read_enable  : read strobe to the FIFO, high in FETCH
//   tx           : serial line, idle high, registered
//   busy         : high in every state except IDLE
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty,
  input  logic       full,
  input  logic       write_enable,
  input  logic [7:0] dout,
  output logic       read_enable,
  output logic       tx,
  output logic       busy
);

  localparam logic [2:0] LastBit = 3'(FrameBits - 3);

  tx_state_e  state_d, state_q;
  logic [7:0] shreg_d, shreg_q;
  logic [2:0] bit_idx_d, bit_idx_q;
  logic       tx_d, tx_q;
  logic       read_enable_d, read_enable_q;
  logic       busy_d, busy_q;
  logic       cnt_load, cnt_en, tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .enable(cnt_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StFetch;
      end
      StFetch: begin
        // The FIFO gives an unblocked write priority over our read; retry until accepted.
        if (!(write_enable && !full)) state_d = StLoad;
      end
      StLoad: begin
        shreg_d   = dout;
        bit_idx_d = 3'd0;
        cnt_load  = 1'b1;
        state_d   = StStart;
      end
      StStart: begin
        cnt_en = 1'b1;
        if (tick) begin
          cnt_load = 1'b1;
          state_d  = StData;
        end
      end
      StData: begin
        cnt_en = 1'b1;
        if (tick) begin
          cnt_load  = 1'b1;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LastBit) begin
            bit_idx_d = 3'd0;
            state_d   = StStop;
          end
        end
      end
      StStop: begin
        cnt_en = 1'b1;
        if (tick) state_d = empty ? StIdle : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    tx_d          = 1'b1;
    read_enable_d = (state_d == StFetch);
    busy_d        = (state_d != StIdle);
    if (state_d == StStart) begin
      tx_d = 1'b0;
    end else if (state_d == StData) begin
      tx_d = shreg_d[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      shreg_q       <= 8'd0;
      bit_idx_q     <= 3'd0;
      tx_q          <= 1'b1;
      read_enable_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_idx_q     <= bit_idx_d;
      tx_q          <= tx_d;
      read_enable_q <= read_enable_d;
      busy_q        <= busy_d;
    end
  end

  assign tx          = tx_q;
  assign read_enable = read_enable_q;
  assign busy        = busy_q;

endmodule
